// File: rtl/axis_pkt_buffer.sv
// Store-and-forward AXI-Stream packet FIFO: a packet becomes visible downstream only once its
// tlast flit is stored; packets that do not fit are discarded whole and counted.
module axis_pkt_buffer #(
    parameter int TDATA_WIDTH = 512,
    parameter int DEPTH       = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [CNT_WIDTH-1:0]       pkt_in_cnt,
    output logic [CNT_WIDTH-1:0]       pkt_out_cnt,
    output logic [CNT_WIDTH-1:0]       pkt_drop_cnt,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
    localparam int AW         = $clog2(DEPTH);
    localparam int PW         = AW + 1;

    typedef enum logic {
        ACCEPT,
        DROP
    } state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]  wr_commit, wr_commit_nxt;
    logic [PW-1:0]  rd_ptr;
    logic           ready_q;
    logic           in_fire;
    logic           out_fire;
    logic           full;
    logic           wr_en;
    logic           in_inc;
    logic           drop_inc;

    logic [TDATA_WIDTH-1:0] mem_data [DEPTH];
    logic [KEEP_WIDTH-1:0]  mem_keep [DEPTH];
    logic                   mem_last [DEPTH];

    assign s_axis_tready = ready_q;
    assign in_fire       = s_axis_tvalid & ready_q;
    // Occupancy counts the speculative partial packet, so it is what limits new writes.
    assign full          = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign fill_level    = wr_ptr - rd_ptr;

    assign m_axis_tvalid = (rd_ptr != wr_commit);
    assign m_axis_tdata  = mem_data[rd_ptr[AW-1:0]];
    assign m_axis_tkeep  = mem_keep[rd_ptr[AW-1:0]];
    assign m_axis_tlast  = mem_last[rd_ptr[AW-1:0]];
    assign out_fire      = m_axis_tvalid & m_axis_tready;

    // NOTE: every output of a combinational block gets a default first; any path that left one
    // unassigned would infer a latch.
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        wr_en         = 1'b0;
        in_inc        = 1'b0;
        drop_inc      = 1'b0;
        case (state)
            ACCEPT: begin
                if (in_fire) begin
                    if (full) begin
                        wr_ptr_nxt = wr_commit;
                        drop_inc   = 1'b1;
                        if (!s_axis_tlast) begin
                            state_nxt = DROP;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        if (s_axis_tlast) begin
                            wr_commit_nxt = wr_ptr + PW'(1);
                            in_inc        = 1'b1;
                        end
                    end
                end
            end
            DROP: begin
                if (in_fire && s_axis_tlast) begin
                    state_nxt = ACCEPT;
                end
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACCEPT;
            ready_q      <= 1'b0;
            wr_ptr       <= '0;
            wr_commit    <= '0;
            rd_ptr       <= '0;
            pkt_in_cnt   <= '0;
            pkt_out_cnt  <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ready_q   <= 1'b1;
            wr_ptr    <= wr_ptr_nxt;
            wr_commit <= wr_commit_nxt;
            if (out_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (in_inc) begin
                pkt_in_cnt <= pkt_in_cnt + CNT_WIDTH'(1);
            end
            if (out_fire && m_axis_tlast) begin
                pkt_out_cnt <= pkt_out_cnt + CNT_WIDTH'(1);
            end
            if (drop_inc) begin
                pkt_drop_cnt <= pkt_drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; pointers alone define which entries are live, and
    // leaving it unreset lets it map onto plain register-file/RAM cells.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr[AW-1:0]] <= s_axis_tdata;
            mem_keep[wr_ptr[AW-1:0]] <= s_axis_tkeep;
            mem_last[wr_ptr[AW-1:0]] <= s_axis_tlast;
        end
    end

endmodule
